// File: rtl/bp_mem_traffic_initiator_pkg.sv
// Shared types for the memory traffic initiator: processor configuration,
// CCE<->memory message enums and the packed command/response message.
package bp_mem_traffic_initiator_pkg;

    typedef enum logic [3:0] {
        e_bp_default_cfg = 4'd0
    } bp_params_e;

    localparam int unsigned paddr_width_gp     = 40;
    localparam int unsigned cce_block_width_gp = 512;
    localparam int unsigned lce_id_width_gp    = 4;
    localparam int unsigned lce_assoc_gp       = 8;
    localparam int unsigned way_id_width_gp    = $clog2(lce_assoc_gp);

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'd0,
        e_cce_mem_wr    = 4'd1,
        e_cce_mem_uc_rd = 4'd2,
        e_cce_mem_uc_wr = 4'd3,
        e_cce_mem_pre   = 4'd4,
        e_cce_mem_amo   = 4'd5
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_msg_size_1  = 3'd0,
        e_mem_msg_size_2  = 3'd1,
        e_mem_msg_size_4  = 3'd2,
        e_mem_msg_size_8  = 3'd3,
        e_mem_msg_size_16 = 3'd4,
        e_mem_msg_size_32 = 3'd5,
        e_mem_msg_size_64 = 3'd6
    } bp_mem_msg_size_e;

    typedef struct packed {
        bp_cce_mem_cmd_type_e           msg_type;
        logic [paddr_width_gp-1:0]      addr;
        bp_mem_msg_size_e               size;
        logic [lce_id_width_gp-1:0]     lce_id;
        logic [way_id_width_gp-1:0]     way_id;
    } bp_cce_mem_msg_header_s;

    typedef struct packed {
        bp_cce_mem_msg_header_s         header;
        logic [cce_block_width_gp-1:0]  data;
    } bp_cce_mem_msg_s;

    // Configuration lookups; every configuration currently maps to the default widths.
    function automatic int unsigned cfg_paddr_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return paddr_width_gp;
            default:          return paddr_width_gp;
        endcase
    endfunction

    function automatic int unsigned cfg_cce_block_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return cce_block_width_gp;
            default:          return cce_block_width_gp;
        endcase
    endfunction

    function automatic int unsigned cfg_lce_id_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return lce_id_width_gp;
            default:          return lce_id_width_gp;
        endcase
    endfunction

    function automatic int unsigned cfg_lce_assoc(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return lce_assoc_gp;
            default:          return lce_assoc_gp;
        endcase
    endfunction

endpackage

// File: rtl/bsg_counter_up_down.sv
// Saturation-free up/down counter used to track in-flight commands.
// Ports: clk_i, reset_i (sync, active-high), up_i/down_i (one step each),
// count_o (current count). Simultaneous up and down leave the count unchanged.
module bsg_counter_up_down #(
    parameter int unsigned max_val_p  = 4,
    parameter int unsigned init_val_p = 0,
    localparam int unsigned width_lp  = $clog2(max_val_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                up_i,
    input  logic                down_i,
    output logic [width_lp-1:0] count_o
);

    logic [width_lp-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= width_lp'(init_val_p);
        end else if (up_i && !down_i) begin
            count_q <= count_q + width_lp'(1);
        end else if (down_i && !up_i) begin
            count_q <= count_q - width_lp'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_mem_traffic_initiator.sv
// Memory traffic initiator: writes num_words_p 8-byte words starting at
// base_addr_p with data addr^pattern_p, then reads them back in order and
// checks the returned data.
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   start_i               starts a run (IDLE), returns to IDLE (DONE)
//   mem_cmd_o/_v_o        command message and valid; mem_cmd_ready_i accepts
//   mem_resp_i/_v_i       response message and valid; mem_resp_yumi_o consumes
//   done_o                high while in DONE
//   error_o               sticky error flag
//   err_count_o           saturating read-data mismatch count
module bp_mem_traffic_initiator
    import bp_mem_traffic_initiator_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    localparam int unsigned paddr_width_p = cfg_paddr_width(bp_params_p),
    parameter logic [paddr_width_p-1:0] base_addr_p = paddr_width_p'(32'h8000_0000),
    parameter int unsigned num_words_p       = 16,
    parameter int unsigned max_outstanding_p = 4,
    parameter logic [63:0] pattern_p         = 64'hDEAD_BEEF_0BAD_F00D
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    output bp_cce_mem_msg_s mem_cmd_o,
    output logic            mem_cmd_v_o,
    input  logic            mem_cmd_ready_i,
    input  bp_cce_mem_msg_s mem_resp_i,
    input  logic            mem_resp_v_i,
    output logic            mem_resp_yumi_o,
    output logic            done_o,
    output logic            error_o,
    output logic [15:0]     err_count_o
);

    localparam int unsigned cce_block_width_p = cfg_cce_block_width(bp_params_p);
    localparam int unsigned lce_id_width_p    = cfg_lce_id_width(bp_params_p);
    localparam int unsigned lce_assoc_p       = cfg_lce_assoc(bp_params_p);
    localparam int unsigned way_id_width_lp   = $clog2(lce_assoc_p);
    localparam int unsigned idx_width_lp      = (num_words_p > 1) ? $clog2(num_words_p) : 1;
    localparam int unsigned cnt_width_lp      = $clog2(max_outstanding_p + 1);

    typedef enum logic [2:0] {
        e_idle,
        e_write,
        e_wr_drain,
        e_read,
        e_rd_drain,
        e_done
    } state_e;

    state_e                   state_q;
    logic [idx_width_lp-1:0]  issue_idx_q;
    logic [idx_width_lp-1:0]  exp_idx_q;
    logic                     error_q;
    logic [15:0]              err_count_q;
    logic                     done_q;
    logic [cnt_width_lp-1:0]  outstanding;

    logic                     cmd_hs;
    logic                     resp_expected;
    logic                     resp_spurious;
    logic                     read_phase;
    logic                     type_bad;
    logic                     read_resp;
    logic                     data_bad;
    logic                     last_word;
    bp_cce_mem_cmd_type_e     phase_type;

    function automatic logic [paddr_width_p-1:0] word_addr(input logic [idx_width_lp-1:0] idx);
        return base_addr_p + (paddr_width_p'(idx) << 3);
    endfunction

    function automatic logic [63:0] word_data(input logic [idx_width_lp-1:0] idx);
        return 64'(word_addr(idx)) ^ pattern_p;
    endfunction

    // Command is a pure decode of registered state, so it holds while stalled.
    always_comb begin
        mem_cmd_o                 = '0;
        mem_cmd_o.header.msg_type = (state_q == e_read) ? e_cce_mem_uc_rd : e_cce_mem_uc_wr;
        mem_cmd_o.header.addr     = word_addr(issue_idx_q);
        mem_cmd_o.header.size     = e_mem_msg_size_8;
        mem_cmd_o.header.lce_id   = lce_id_width_p'(0);
        mem_cmd_o.header.way_id   = way_id_width_lp'(0);
        if (state_q != e_read) begin
            mem_cmd_o.data = cce_block_width_p'(word_data(issue_idx_q));
        end
    end

    // Valid is gated by reset so an abandoned run issues nothing more.
    assign mem_cmd_v_o     = !reset_i
                             && (state_q == e_write || state_q == e_read)
                             && (outstanding < cnt_width_lp'(max_outstanding_p));
    assign cmd_hs          = mem_cmd_v_o && mem_cmd_ready_i;
    assign mem_resp_yumi_o = mem_resp_v_i;

    // Response classification; anything arriving with nothing in flight is an error.
    assign resp_expected = mem_resp_v_i && (outstanding != '0);
    assign resp_spurious = mem_resp_v_i && (outstanding == '0);
    assign read_phase    = (state_q == e_read) || (state_q == e_rd_drain);
    assign phase_type    = read_phase ? e_cce_mem_uc_rd : e_cce_mem_uc_wr;
    assign type_bad      = resp_expected && (mem_resp_i.header.msg_type != phase_type);
    assign read_resp     = resp_expected && read_phase
                           && (mem_resp_i.header.msg_type == e_cce_mem_uc_rd);
    assign data_bad      = read_resp && (mem_resp_i.data[63:0] != word_data(exp_idx_q));
    assign last_word     = (issue_idx_q == idx_width_lp'(num_words_p - 1));

    logic unused_resp_bits;
    assign unused_resp_bits = ^{mem_resp_i.data[cce_block_width_p-1:64],
                                mem_resp_i.header.addr, mem_resp_i.header.size,
                                mem_resp_i.header.lce_id, mem_resp_i.header.way_id};

    bsg_counter_up_down #(
        .max_val_p (max_outstanding_p),
        .init_val_p(0)
    ) u_outstanding (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .up_i   (cmd_hs),
        .down_i (resp_expected),
        .count_o(outstanding)
    );

    // Run sequencing plus response checking; a start clears the run results last.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= e_idle;
            issue_idx_q <= '0;
            exp_idx_q   <= '0;
            error_q     <= 1'b0;
            err_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            if (resp_spurious || type_bad || data_bad) begin
                error_q <= 1'b1;
            end
            if (data_bad && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end
            if (read_resp) begin
                exp_idx_q <= exp_idx_q + idx_width_lp'(1);
            end

            case (state_q)
                e_idle: begin
                    if (start_i) begin
                        state_q     <= e_write;
                        issue_idx_q <= '0;
                        exp_idx_q   <= '0;
                        error_q     <= 1'b0;
                        err_count_q <= '0;
                    end
                end
                e_write: begin
                    if (cmd_hs) begin
                        if (last_word) begin
                            state_q     <= e_wr_drain;
                            issue_idx_q <= '0;
                        end else begin
                            issue_idx_q <= issue_idx_q + idx_width_lp'(1);
                        end
                    end
                end
                e_wr_drain: begin
                    if (outstanding == '0) begin
                        state_q <= e_read;
                    end
                end
                e_read: begin
                    if (cmd_hs) begin
                        if (last_word) begin
                            state_q     <= e_rd_drain;
                            issue_idx_q <= '0;
                        end else begin
                            issue_idx_q <= issue_idx_q + idx_width_lp'(1);
                        end
                    end
                end
                e_rd_drain: begin
                    if (outstanding == '0) begin
                        state_q <= e_done;
                        done_q  <= 1'b1;
                    end
                end
                e_done: begin
                    if (start_i) begin
                        state_q     <= e_idle;
                        done_q      <= 1'b0;
                        issue_idx_q <= '0;
                        exp_idx_q   <= '0;
                        error_q     <= 1'b0;
                        err_count_q <= '0;
                    end
                end
                default: state_q <= e_idle;
            endcase
        end
    end

    assign done_o      = done_q;
    assign error_o     = error_q;
    assign err_count_o = err_count_q;

endmodule
